// File: rtl/bp_ctrl.sv
// Branch-predictor controller: gshare PHT, non-speculative BHR and a direct-mapped BTB,
// with a post-reset initialisation sweep and a saturating misprediction counter.
module bp_ctrl #(
    parameter int unsigned PHT_IDX_BITS = 8,
    parameter int unsigned BTB_IDX_BITS = 4,
    parameter int unsigned DBITS        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lk_valid,
    input  logic [DBITS-1:0]        lk_pc,
    output logic                    lk_ready,
    output logic                    pred_valid,
    output logic                    pred_taken,
    output logic [DBITS-1:0]        pred_target,
    output logic [PHT_IDX_BITS-1:0] pred_bhr,
    output logic [PHT_IDX_BITS-1:0] pred_pht_idx,
    input  logic                    upd_valid,
    input  logic                    upd_is_branch,
    input  logic [DBITS-1:0]        upd_pc,
    input  logic [PHT_IDX_BITS-1:0] upd_pht_idx,
    input  logic                    upd_taken,
    input  logic [DBITS-1:0]        upd_target,
    input  logic                    upd_mispredict,
    output logic                    init_done,
    output logic [31:0]             mispred_cnt
);

    localparam int unsigned PHT_SIZE = 1 << PHT_IDX_BITS;
    localparam int unsigned BTB_SIZE = 1 << BTB_IDX_BITS;
    localparam int unsigned TAG_BITS = DBITS - BTB_IDX_BITS - 2;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                    state;
    logic [PHT_IDX_BITS-1:0]   ptr;
    logic [PHT_IDX_BITS-1:0]   bhr;

    logic [1:0]                pht        [PHT_SIZE];
    logic [BTB_SIZE-1:0]       btb_valid;
    logic [TAG_BITS-1:0]       btb_tag    [BTB_SIZE];
    logic [DBITS-1:0]          btb_target [BTB_SIZE];

    logic                      run;
    logic                      lk_fire;
    logic                      upd_fire;
    logic [PHT_IDX_BITS-1:0]   lk_idx;
    logic [BTB_IDX_BITS-1:0]   lk_set;
    logic [TAG_BITS-1:0]       lk_tag;
    logic [BTB_IDX_BITS-1:0]   upd_set;
    logic [TAG_BITS-1:0]       upd_tag;
    logic                      lk_hit;
    logic                      lk_taken;
    logic [1:0]                upd_ctr;
    logic [1:0]                upd_ctr_next;
    logic                      unused;

    // Lookup and update decode; the PC's byte-offset bits carry no information
    assign run      = (state == ST_RUN);
    assign lk_fire  = lk_valid && run;
    assign upd_fire = upd_valid && run;
    assign lk_idx   = bhr ^ lk_pc[PHT_IDX_BITS+1:2];
    assign lk_set   = lk_pc[BTB_IDX_BITS+1:2];
    assign lk_tag   = lk_pc[DBITS-1:BTB_IDX_BITS+2];
    assign upd_set  = upd_pc[BTB_IDX_BITS+1:2];
    assign upd_tag  = upd_pc[DBITS-1:BTB_IDX_BITS+2];
    assign lk_hit   = btb_valid[lk_set] && (btb_tag[lk_set] == lk_tag);
    assign lk_taken = lk_hit && pht[lk_idx][1];
    assign upd_ctr  = pht[upd_pht_idx];
    assign unused   = ^{lk_pc[1:0], upd_pc[1:0]};

    always_comb begin
        upd_ctr_next = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != 2'd3) upd_ctr_next = 2'(upd_ctr + 2'd1);
        end else begin
            if (upd_ctr != 2'd0) upd_ctr_next = 2'(upd_ctr - 2'd1);
        end
    end

    // Table storage: swept during INIT, trained by resolved updates in RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!run) begin
                pht[ptr] <= 2'b01;
                btb_valid[ptr[BTB_IDX_BITS-1:0]] <= 1'b0;
            end else if (upd_fire) begin
                if (upd_is_branch) pht[upd_pht_idx] <= upd_ctr_next;
                if (upd_taken) begin
                    btb_valid[upd_set]  <= 1'b1;
                    btb_tag[upd_set]    <= upd_tag;
                    btb_target[upd_set] <= upd_target;
                end
            end
        end
    end

    // Control FSM, BHR, counters and registered prediction response
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_INIT;
            ptr          <= '0;
            bhr          <= '0;
            mispred_cnt  <= '0;
            lk_ready     <= 1'b0;
            init_done    <= 1'b0;
            pred_valid   <= 1'b0;
            pred_taken   <= 1'b0;
            pred_target  <= '0;
            pred_bhr     <= '0;
            pred_pht_idx <= '0;
        end else begin
            if (upd_valid && upd_mispredict && (mispred_cnt != 32'hFFFF_FFFF))
                mispred_cnt <= 32'(mispred_cnt + 32'd1);

            case (state)
                ST_INIT: begin
                    ptr <= PHT_IDX_BITS'(ptr + 1'b1);
                    if (ptr == '1) begin
                        state     <= ST_RUN;
                        lk_ready  <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (upd_valid && upd_is_branch)
                        bhr <= {bhr[PHT_IDX_BITS-2:0], upd_taken};
                end
                default: state <= ST_INIT;
            endcase

            pred_valid <= lk_fire;
            if (lk_fire) begin
                pred_taken   <= lk_taken;
                pred_target  <= lk_taken ? btb_target[lk_set] : DBITS'(lk_pc + DBITS'(4));
                pred_bhr     <= bhr;
                pred_pht_idx <= lk_idx;
            end
        end
    end

endmodule

// File: tb/tb_bp_ctrl.sv
// Self-checking bench for bp_ctrl: directed scenarios plus random traffic
// compared against a table-level behavioural model of the predictor.
module tb_bp_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        lk_ready;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [7:0]  pred_bhr;
    logic [7:0]  pred_pht_idx;
    logic        upd_valid;
    logic        upd_is_branch;
    logic [31:0] upd_pc;
    logic [7:0]  upd_pht_idx;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        init_done;
    logic [31:0] mispred_cnt;

    int errors = 0;
    int checks = 0;

    bp_ctrl dut (
        .clk(clk), .reset(reset),
        .lk_valid(lk_valid), .lk_pc(lk_pc), .lk_ready(lk_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_bhr(pred_bhr), .pred_pht_idx(pred_pht_idx),
        .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_pc(upd_pc),
        .upd_pht_idx(upd_pht_idx), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict),
        .init_done(init_done), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          m_pht [256];
    bit          m_bv  [16];
    logic [25:0] m_bt  [16];
    logic [31:0] m_btgt[16];
    logic [7:0]  m_bhr;
    logic [31:0] m_cnt;
    bit          m_run;
    int          m_left;

    logic        e_pv, e_tk, e_rdy;
    logic [31:0] e_tgt;
    logic [7:0]  e_bhr, e_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output
    task automatic cyc(input logic rst, input logic lv, input logic [31:0] lpc,
                       input logic uv, input logic ub, input logic [31:0] upc,
                       input logic [7:0] uidx, input logic ut, input logic [31:0] utgt,
                       input logic um);
        logic [7:0]  i;
        logic [3:0]  s;
        int          c;
        reset = rst; lk_valid = lv; lk_pc = lpc;
        upd_valid = uv; upd_is_branch = ub; upd_pc = upc; upd_pht_idx = uidx;
        upd_taken = ut; upd_target = utgt; upd_mispredict = um;
        if (rst) begin
            m_bhr = 0; m_cnt = 0; m_run = 0; m_left = 256;
            foreach (m_pht[k]) m_pht[k] = 1;
            foreach (m_bv[k]) m_bv[k] = 0;
            e_pv = 0; e_tk = 0; e_tgt = 0; e_bhr = 0; e_idx = 0;
        end else begin
            e_pv = lv && m_run;
            if (e_pv) begin
                i = m_bhr ^ lpc[9:2];
                s = lpc[5:2];
                e_tk  = m_bv[s] && (m_bt[s] == lpc[31:6]) && (m_pht[i] >= 2);
                e_tgt = e_tk ? m_btgt[s] : lpc + 32'd4;
                e_bhr = m_bhr;
                e_idx = i;
            end
            if (uv && um && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (uv && m_run) begin
                if (ub) begin
                    c = m_pht[uidx] + (ut ? 1 : -1);
                    m_pht[uidx] = (c > 3) ? 3 : (c < 0) ? 0 : c;
                    m_bhr = {m_bhr[6:0], ut};
                end
                if (ut) begin
                    s = upc[5:2];
                    m_bv[s] = 1; m_bt[s] = upc[31:6]; m_btgt[s] = utgt;
                end
            end
            if (!m_run) begin
                m_left--;
                if (m_left == 0) m_run = 1;
            end
        end
        e_rdy = m_run && !rst;
        @(posedge clk);
        #1;
        chk("lk_ready", 64'(lk_ready), 64'(e_rdy));
        chk("init_done", 64'(init_done), 64'(e_rdy));
        chk("pred_valid", 64'(pred_valid), 64'(e_pv));
        chk("pred_taken", 64'(pred_taken), 64'(e_tk));
        chk("pred_target", 64'(pred_target), 64'(e_tgt));
        chk("pred_bhr", 64'(pred_bhr), 64'(e_bhr));
        chk("pred_pht_idx", 64'(pred_pht_idx), 64'(e_idx));
        chk("mispred_cnt", 64'(mispred_cnt), 64'(m_cnt));
        @(negedge clk);
    endtask

    task automatic lk(input logic [31:0] pc);
        cyc(1'b0, 1'b1, pc, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic upd(input logic br, input logic [31:0] pc, input logic [7:0] idx,
                       input logic t, input logic [31:0] tgt, input logic m);
        cyc(1'b0, 1'b0, 32'd0, 1'b1, br, pc, idx, t, tgt, m);
    endtask

    initial begin
        int n;
        logic [31:0] rpc, upc_r;
        @(negedge clk);

        // Reset, partial INIT, then reset again mid-sweep
        cyc(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 1'b0);
        chk("rst_cnt", 64'(mispred_cnt), 64'd0);
        chk("rst_pred_target", 64'(pred_target), 64'd0);
        for (int k = 0; k < 100; k++) lk(32'h100);
        cyc(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0, 32'd0, 1'b0);

        // Full INIT with lookups held and two mispredicted updates dropped
        n = 0;
        while (!lk_ready && n < 1000) begin
            cyc(1'b0, 1'b1, 32'h100, (n == 10 || n == 20), 1'b1, 32'h100, 8'h40,
                1'b1, 32'h999, 1'b1);
            n++;
        end
        chk("init_len", 64'(n), 64'd256);
        chk("init_cnt", 64'(mispred_cnt), 64'd2);

        lk(32'h100);
        chk("first_taken", 64'(pred_taken), 64'd0);
        chk("first_target", 64'(pred_target), 64'h104);
        chk("first_idx", 64'(pred_pht_idx), 64'h40);

        for (int k = 0; k < 3; k++) upd(1'b1, 32'h100, 8'h40, 1'b1, 32'h200, 1'b1);
        chk("five_mispred", 64'(mispred_cnt), 64'd5);
        lk(32'h100);
        chk("bhr_after3", 64'(pred_bhr), 64'h07);

        upd(1'b1, 32'h100, 8'h40, 1'b1, 32'h200, 1'b0);
        for (int k = 0; k < 8; k++) upd(1'b1, 32'h0, 8'h00, 1'b0, 32'h0, 1'b0);
        lk(32'h100);
        chk("sat_taken", 64'(pred_taken), 64'd1);
        chk("sat_target", 64'(pred_target), 64'h200);

        // Weakly-taken counter at idx 0x20, then a jump into BTB set 0
        upd(1'b1, 32'h44, 8'h20, 1'b1, 32'h400, 1'b0);
        for (int k = 0; k < 8; k++) upd(1'b1, 32'h4, 8'h01, 1'b0, 32'h0, 1'b0);
        upd(1'b0, 32'h80, 8'h55, 1'b1, 32'h300, 1'b0);
        lk(32'h80);
        chk("jump_bhr", 64'(pred_bhr), 64'h00);
        chk("jump_taken", 64'(pred_taken), 64'd1);
        chk("jump_target", 64'(pred_target), 64'h300);

        // Same-cycle lookup and update to the same PHT index
        for (int k = 0; k < 2; k++) upd(1'b1, 32'h0, 8'h40, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h104, 8'h40, 1'b1, 32'h200, 1'b0);
        chk("rbw_old", 64'(pred_taken), 64'd0);
        lk(32'h104);
        chk("rbw_new", 64'(pred_taken), 64'd1);
        chk("rbw_idx", 64'(pred_pht_idx), 64'h40);

        // Random traffic over a small PC window so BTB hits and conflicts occur
        for (int k = 0; k < 600; k++) begin
            rpc   = (32'($urandom_range(0, 31)) << 2) | (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0);
            upc_r = (32'($urandom_range(0, 31)) << 2) | (($urandom_range(0, 3) == 0) ? 32'h1000 : 32'h0);
            cyc(1'b0, ($urandom_range(0, 3) != 0), rpc, ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 3) != 0), upc_r, 8'($urandom_range(0, 255)),
                ($urandom_range(0, 2) != 0), 32'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Counter saturation
        force dut.mispred_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.mispred_cnt;
        m_cnt = 32'hFFFF_FFFF;
        upd(1'b1, 32'h0, 8'h10, 1'b0, 32'h0, 1'b1);
        chk("cnt_sat", 64'(mispred_cnt), 64'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
